// File: rtl/mem_port_arbiter_if.sv
// Request/response and byte-RAM signals shared between the two requesters, the arbiter and the RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        mem_err;
   logic        ram_en;
   logic        ram_we;
   logic [7:0]  ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic        busy;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_rdata,
      output if_ack, if_rdata, mem_ack, mem_rdata, mem_err,
      output ram_en, ram_we, ram_addr, ram_wdata, busy
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_rdata,
      input  if_ack, if_rdata, mem_ack, mem_rdata, mem_err,
      input  ram_en, ram_we, ram_addr, ram_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto a 256x8 byte RAM, one big-endian byte beat per cycle.
// Grant-to-ack is N+1 cycles (1 for rejected accesses); requesters hold req until their ack pulse.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 3
) (
   input logic              clk,
   input logic              reset_n,
   mem_port_arbiter_if.slave bus
);

   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

   state_t        state, state_nxt;
   logic          owner_if;
   logic [7:0]    base;
   logic [1:0]    last;
   logic [1:0]    k;
   logic          we_q;
   logic          err_q;
   logic [31:0]   wdata_q;
   logic [31:0]   asm_q;
   logic [CW-1:0] cnt;

   logic          grant;
   logic          pick_if;
   logic          mem_bad;
   logic [1:0]    idx;
   logic          unused_addr;

   assign unused_addr = ^{bus.if_addr[31:8], bus.if_addr[1:0], bus.mem_addr[31:8]};

   assign grant   = bus.if_req || bus.mem_req;
   assign pick_if = bus.if_req && (!bus.mem_req || (cnt == LIMIT));
   assign mem_bad = (bus.mem_size == 2'b11) ||
                    ((bus.mem_size == 2'b01) && bus.mem_addr[0]) ||
                    ((bus.mem_size == 2'b10) && (bus.mem_addr[1:0] != 2'b00));
   // Beat k carries byte (last-k), so the first beat moves the most significant byte.
   assign idx = last - k;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      bus.ram_en    = 1'b0;
      bus.ram_we    = 1'b0;
      bus.ram_addr  = 8'h00;
      bus.ram_wdata = 8'h00;
      bus.if_ack    = 1'b0;
      bus.if_rdata  = 32'h0;
      bus.mem_ack   = 1'b0;
      bus.mem_err   = 1'b0;
      bus.mem_rdata = 32'h0;
      bus.busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (grant) begin
               state_nxt = (!pick_if && mem_bad) ? DONE : BEAT;
            end
         end
         BEAT: begin
            bus.ram_en   = 1'b1;
            bus.ram_we   = we_q;
            bus.ram_addr = base + {6'b0, k};
            case (idx)
               2'd0:    bus.ram_wdata = wdata_q[7:0];
               2'd1:    bus.ram_wdata = wdata_q[15:8];
               2'd2:    bus.ram_wdata = wdata_q[23:16];
               default: bus.ram_wdata = wdata_q[31:24];
            endcase
            if (k == last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (owner_if) begin
               bus.if_ack   = 1'b1;
               bus.if_rdata = asm_q;
            end else begin
               bus.mem_ack   = 1'b1;
               bus.mem_err   = err_q;
               bus.mem_rdata = err_q ? 32'h0 : asm_q;
            end
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner_if <= 1'b0;
         base     <= 8'h00;
         last     <= 2'd0;
         k        <= 2'd0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         wdata_q  <= 32'h0;
         asm_q    <= 32'h0;
         cnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant) begin
                  k     <= 2'd0;
                  asm_q <= 32'h0;
                  if (pick_if) begin
                     // Fetches are always whole words; low address bits are dropped, never flagged.
                     owner_if <= 1'b1;
                     base     <= {bus.if_addr[7:2], 2'b00};
                     last     <= 2'd3;
                     we_q     <= 1'b0;
                     err_q    <= 1'b0;
                     wdata_q  <= 32'h0;
                     cnt      <= '0;
                  end else begin
                     owner_if <= 1'b0;
                     base     <= bus.mem_addr[7:0];
                     case (bus.mem_size)
                        2'b00:   last <= 2'd0;
                        2'b01:   last <= 2'd1;
                        default: last <= 2'd3;
                     endcase
                     we_q     <= bus.mem_we;
                     err_q    <= mem_bad;
                     wdata_q  <= bus.mem_wdata;
                     cnt      <= (cnt == LIMIT) ? cnt : cnt + 1'b1;
                  end
               end
            end
            BEAT: begin
               if (!we_q) begin
                  asm_q <= {asm_q[23:0], bus.ram_rdata};
               end
               k <= k + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: table of single transactions plus hand sequences for starvation and mid-access reset.
module tb_mem_port_arbiter;

   logic clk;
   logic reset_n;
   logic load_ram;
   logic [7:0] ram [256];

   int checks;
   int errors;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.STARVE_LIMIT(3)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.ram_rdata = ram[bus.ram_addr];

   always @(posedge clk) begin
      if (load_ram) begin
         ram[8'h00] <= 8'h12; ram[8'h01] <= 8'h34; ram[8'h02] <= 8'h56; ram[8'h03] <= 8'h78;
         ram[8'hFC] <= 8'hA1; ram[8'hFD] <= 8'hB2; ram[8'hFE] <= 8'hC3; ram[8'hFF] <= 8'hD4;
         ram[8'h10] <= 8'h00; ram[8'h11] <= 8'h00;
         ram[8'h20] <= 8'h00; ram[8'h21] <= 8'h00; ram[8'h22] <= 8'h00; ram[8'h23] <= 8'h00;
         ram[8'h40] <= 8'h00; ram[8'h41] <= 8'h00; ram[8'h42] <= 8'h00; ram[8'h43] <= 8'h00;
      end else if (bus.ram_en && bus.ram_we) begin
         ram[bus.ram_addr] <= bus.ram_wdata;
      end
   end

   typedef struct {
      bit          is_if;
      bit          we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          nbeat;
      logic [7:0]  base;
      int          lat;
      bit          err;
      bit          chk_rd;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.if_req    = 1'b0;
      bus.if_addr   = 32'h0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_size  = 2'b00;
      bus.mem_addr  = 32'h0;
      bus.mem_wdata = 32'h0;
   endtask

   task automatic run_txn(input vec_t v, input int id);
      int         cyc;
      int         beats;
      bit         got;
      logic [7:0] addrs [4];
      @(posedge clk); #1;
      if (v.is_if) begin
         bus.if_req  = 1'b1;
         bus.if_addr = v.addr;
      end else begin
         bus.mem_req   = 1'b1;
         bus.mem_we    = v.we;
         bus.mem_size  = v.size;
         bus.mem_addr  = v.addr;
         bus.mem_wdata = v.wdata;
      end
      got = 0; beats = 0; cyc = 0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         if (bus.ram_en) begin
            if (beats < 4) addrs[beats] = bus.ram_addr;
            beats++;
         end
         if (bus.if_ack || bus.mem_ack) begin
            got = 1;
            check($sformatf("v%0d latency", id), cyc, v.lat);
            check($sformatf("v%0d owner", id), {30'b0, bus.if_ack, bus.mem_ack}, v.is_if ? 32'd2 : 32'd1);
            check($sformatf("v%0d busy", id), {31'b0, bus.busy}, 32'd1);
            if (!v.is_if) check($sformatf("v%0d mem_err", id), {31'b0, bus.mem_err}, {31'b0, v.err});
            if (v.chk_rd) check($sformatf("v%0d rdata", id), v.is_if ? bus.if_rdata : bus.mem_rdata, v.rdata);
         end
         cyc++;
      end
      if (!got) check($sformatf("v%0d ack timeout", id), 32'd0, 32'd1);
      check($sformatf("v%0d beats", id), beats, v.nbeat);
      for (int i = 0; i < 4; i++) begin
         if (i < beats && i < v.nbeat) begin
            check($sformatf("v%0d ram_addr beat%0d", id, i), {24'b0, addrs[i]}, {24'b0, 8'(v.base + 8'(i))});
         end
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   initial begin
      int  nack;
      int  cyc;
      bit  found;
      bit  seen_ack;
      checks   = 0;
      errors   = 0;
      reset_n  = 1'b0;
      load_ram = 1'b1;
      idle_inputs();

      //                 is_if we size   addr          wdata         n  base   lat err chk rdata
      vecs[0]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0000, 32'h0,        4, 8'h00, 5, 1'b0, 1'b1, 32'h1234_5678};
      vecs[1]  = '{1'b0, 1'b1, 2'b01, 32'h0000_0010, 32'h0000_BEEF, 2, 8'h10, 3, 1'b0, 1'b0, 32'h0};
      vecs[2]  = '{1'b0, 1'b0, 2'b00, 32'h0000_0011, 32'h0,        1, 8'h11, 2, 1'b0, 1'b1, 32'h0000_00EF};
      vecs[3]  = '{1'b0, 1'b0, 2'b01, 32'h0000_0010, 32'h0,        2, 8'h10, 3, 1'b0, 1'b1, 32'h0000_BEEF};
      vecs[4]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0102, 32'h0,        0, 8'h00, 1, 1'b1, 1'b1, 32'h0};
      vecs[5]  = '{1'b1, 1'b0, 2'b10, 32'h0000_00FC, 32'h0,        4, 8'hFC, 5, 1'b0, 1'b1, 32'hA1B2_C3D4};
      vecs[6]  = '{1'b0, 1'b0, 2'b00, 32'h0000_01FF, 32'h0,        1, 8'hFF, 2, 1'b0, 1'b1, 32'h0000_00D4};
      vecs[7]  = '{1'b0, 1'b0, 2'b11, 32'h0000_0000, 32'h0,        0, 8'h00, 1, 1'b1, 1'b1, 32'h0};
      vecs[8]  = '{1'b0, 1'b0, 2'b01, 32'h0000_0021, 32'h0,        0, 8'h00, 1, 1'b1, 1'b1, 32'h0};
      vecs[9]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0003, 32'h0,        4, 8'h00, 5, 1'b0, 1'b1, 32'h1234_5678};
      vecs[10] = '{1'b0, 1'b1, 2'b10, 32'h0000_0040, 32'hCAFE_F00D, 4, 8'h40, 5, 1'b0, 1'b0, 32'h0};
      vecs[11] = '{1'b0, 1'b0, 2'b10, 32'h0000_0040, 32'h0,        4, 8'h40, 5, 1'b0, 1'b1, 32'hCAFE_F00D};
      vecs[12] = '{1'b0, 1'b0, 2'b01, 32'h0000_0102, 32'h0,        2, 8'h02, 3, 1'b0, 1'b1, 32'h0000_5678};
      vecs[13] = '{1'b0, 1'b1, 2'b00, 32'h0000_0043, 32'h1234_56AB, 1, 8'h43, 2, 1'b0, 1'b0, 32'h0};
      vecs[14] = '{1'b0, 1'b0, 2'b10, 32'h0000_0040, 32'h0,        4, 8'h40, 5, 1'b0, 1'b1, 32'hCAFE_F0AB};

      repeat (2) @(posedge clk);
      @(negedge clk);
      load_ram = 1'b0;
      check("reset busy",     {31'b0, bus.busy},   32'd0);
      check("reset ram_en",   {31'b0, bus.ram_en}, 32'd0);
      check("reset acks",     {29'b0, bus.if_ack, bus.mem_ack, bus.mem_err}, 32'd0);
      check("reset rdata",    bus.if_rdata | bus.mem_rdata, 32'd0);
      check("reset ram bus",  {15'b0, bus.ram_we, bus.ram_addr, bus.ram_wdata}, 32'd0);
      #2 reset_n = 1'b1;

      for (int i = 0; i < 15; i++) run_txn(vecs[i], i);

      check("ram[10]", {24'b0, ram[8'h10]}, 32'h0000_00BE);
      check("ram[11]", {24'b0, ram[8'h11]}, 32'h0000_00EF);

      // Starvation: both requests held; after a reset the counter restarts from zero.
      @(negedge clk); reset_n = 1'b0;
      #2 reset_n = 1'b1;
      @(posedge clk); #1;
      bus.if_req   = 1'b1; bus.if_addr  = 32'h0;
      bus.mem_req  = 1'b1; bus.mem_we   = 1'b0;
      bus.mem_size = 2'b00; bus.mem_addr = 32'h11;
      nack = 0; cyc = 0;
      while (nack < 8 && cyc < 100) begin
         @(negedge clk);
         if (bus.if_ack || bus.mem_ack) begin
            check($sformatf("starve grant%0d is_if", nack), {31'b0, bus.if_ack},
                  (nack == 3 || nack == 7) ? 32'd1 : 32'd0);
            nack++;
         end
         cyc++;
      end
      if (nack < 8) check("starve ack timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      idle_inputs();

      // Word store to 0x20, reset lands during the third beat.
      @(posedge clk); #1;
      bus.mem_req   = 1'b1; bus.mem_we   = 1'b1;
      bus.mem_size  = 2'b10; bus.mem_addr = 32'h20;
      bus.mem_wdata = 32'hA1A2_A3A4;
      found = 0; seen_ack = 0; cyc = 0;
      while (!found && cyc < 10) begin
         @(negedge clk);
         if (bus.mem_ack || bus.if_ack) seen_ack = 1;
         if (bus.ram_en && bus.ram_addr == 8'h22) found = 1;
         cyc++;
      end
      if (!found) check("reset-mid beat2 timeout", 32'd0, 32'd1);
      reset_n = 1'b0;
      #1;
      check("mid-reset ram_en", {31'b0, bus.ram_en}, 32'd0);
      check("mid-reset ram bus", {15'b0, bus.ram_we, bus.ram_addr, bus.ram_wdata}, 32'd0);
      check("mid-reset busy", {31'b0, bus.busy}, 32'd0);
      idle_inputs();
      repeat (2) begin
         @(negedge clk);
         if (bus.mem_ack || bus.if_ack) seen_ack = 1;
      end
      #2 reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (bus.mem_ack || bus.if_ack) seen_ack = 1;
      end
      check("mid-reset no ack", {31'b0, seen_ack}, 32'd0);
      check("ram[20]", {24'b0, ram[8'h20]}, 32'h0000_00A1);
      check("ram[21]", {24'b0, ram[8'h21]}, 32'h0000_00A2);
      check("ram[22]", {24'b0, ram[8'h22]}, 32'h0000_0000);
      check("ram[23]", {24'b0, ram[8'h23]}, 32'h0000_0000);

      // Service resumes normally after the aborted access.
      run_txn(vecs[0], 100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
